// File: rtl/l1_rx_sync_if.sv
// l1_rx_sync_if: two-phase switch handshake plus packet stream and status, seen from both ends.
interface l1_rx_sync_if #(
    parameter int DATA_W     = 15,
    parameter int ADDR_W     = 5,
    parameter int MSG_W      = 10,
    parameter int FIFO_DEPTH = 4
);
    logic                          req_in;
    logic [DATA_W-1:0]             data_in;
    logic                          ack_out;
    logic                          m_valid;
    logic                          m_ready;
    logic [MSG_W/2-1:0]            m_neuron;
    logic [MSG_W/2-1:0]            m_slot;
    logic [ADDR_W-1:0]             m_dest;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic [15:0]                   pkt_count;
    logic                          err_zero_dest;

    modport master (
        output req_in, data_in, m_ready,
        input  ack_out, m_valid, m_neuron, m_slot, m_dest, fifo_level, pkt_count, err_zero_dest
    );

    modport slave (
        input  req_in, data_in, m_ready,
        output ack_out, m_valid, m_neuron, m_slot, m_dest, fifo_level, pkt_count, err_zero_dest
    );
endinterface

// File: rtl/l1_rx_sync.sv
// l1_rx_sync: receives two-phase tokens from a switch L1 port, queues valid packets in a FIFO.
module l1_rx_sync #(
    parameter int DATA_W     = 15,
    parameter int ADDR_W     = 5,
    parameter int MSG_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    l1_rx_sync_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int HW = MSG_W / 2;
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

    state_t            state;
    logic [1:0]        sync;
    logic              req_s;
    logic              ack;
    logic              err;
    logic              pending;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       level;
    logic [15:0]       pkt_cnt;

    assign req_s   = sync[1];
    assign pending = req_s != ack;
    assign push    = state == COMMIT && hold[ADDR_W-1:0] != '0;
    assign pop     = level != '0 && bus.m_ready;
    assign head    = mem[rd_ptr];

    assign bus.ack_out       = ack;
    assign bus.m_valid       = level != '0;
    assign bus.m_dest        = head[ADDR_W-1:0];
    assign bus.m_slot        = head[ADDR_W +: HW];
    assign bus.m_neuron      = head[ADDR_W+HW +: HW];
    assign bus.fifo_level    = level;
    assign bus.pkt_count     = pkt_cnt;
    assign bus.err_zero_dest = err;

    // Two-flop synchronizer: the only consumer of the raw request line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], bus.req_in};
    end

    // Handshake FSM; ack flips as CAPTURE latches data so it lands on the 4th edge after a request toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hold  <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (pending && level != FULL) state <= CAPTURE;
                CAPTURE: begin
                    hold  <= bus.data_in;
                    ack   <= ~ack;
                    state <= COMMIT;
                end
                COMMIT:  begin
                    err   <= err | (hold[ADDR_W-1:0] == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and saturating accepted-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            pkt_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (push && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

    // Packet storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= hold;
    end
endmodule
